// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: grants one request at a time,
// turns sub-word stores into read-merge-write sequences and returns load data or a store ack.
module dmem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int XLEN       = 32,
  parameter int STRB       = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            m0_valid,
  output logic            m0_ready,
  input  logic [XLEN-1:0] m0_addr,
  input  logic            m0_we,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic [STRB-1:0] m0_wstrb,
  output logic            m0_rvalid,
  output logic [XLEN-1:0] m0_rdata,

  input  logic            m1_valid,
  output logic            m1_ready,
  input  logic [XLEN-1:0] m1_addr,
  input  logic            m1_we,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic [STRB-1:0] m1_wstrb,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m1_rdata,

  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, MERGE, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant;   // 0 = m0, 1 = m1

  logic            gnt_valid;
  logic            gnt_id;
  logic [XLEN-1:2] gnt_addr;
  logic            gnt_we;
  logic [XLEN-1:0] gnt_wdata;
  logic [STRB-1:0] gnt_wstrb;
  logic            accept;

  logic            lat_id;
  logic [XLEN-1:2] lat_addr;
  logic            lat_we;
  logic [XLEN-1:0] lat_wdata;
  logic [STRB-1:0] lat_wstrb;
  logic [XLEN-1:0] merged;

  // Byte offset bits never reach dmem; the word address alone selects the location.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    gnt_valid = m0_valid | m1_valid;
    gnt_id    = m1_valid;
    if (m0_valid && m1_valid) begin
      gnt_id = FIXED_PRIO ? 1'b0 : ~last_grant;
    end
    gnt_addr  = gnt_id ? m1_addr[XLEN-1:2] : m0_addr[XLEN-1:2];
    gnt_we    = gnt_id ? m1_we    : m0_we;
    gnt_wdata = gnt_id ? m1_wdata : m0_wdata;
    gnt_wstrb = gnt_id ? m1_wstrb : m0_wstrb;
  end

  assign accept   = rst_n && (state == IDLE) && gnt_valid;
  assign m0_ready = accept && !gnt_id;
  assign m1_ready = accept &&  gnt_id;

  always_comb begin
    merged = mem_rdata;
    for (int i = 0; i < STRB; i++) begin
      if (lat_wstrb[i]) merged[8*i +: 8] = lat_wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = {lat_addr, 2'b00};
    mem_wdata = lat_wdata;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        mem_addr  = {gnt_addr, 2'b00};
        mem_wdata = gnt_wdata;
        if (gnt_valid) begin
          // Partial stores need the old word first; everything else finishes in one dmem cycle.
          if (gnt_we && (|gnt_wstrb) && !(&gnt_wstrb)) begin
            state_nxt = MERGE;
          end else begin
            mem_we    = gnt_we && (&gnt_wstrb);
            state_nxt = RESP;
          end
        end
      end
      MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A reset caught mid-merge must not commit the half-built word.
    if (!rst_n) mem_we = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (accept) last_grant <= gnt_id;
      if (state == RESP) begin
        if (lat_id) begin
          m1_rvalid <= 1'b1;
          m1_rdata  <= lat_we ? '0 : mem_rdata;
        end else begin
          m0_rvalid <= 1'b1;
          m0_rdata  <= lat_we ? '0 : mem_rdata;
        end
      end
    end
  end

  // NOTE: the request latch is pure datapath and is only read after a fresh accept, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_id    <= gnt_id;
      lat_addr  <= gnt_addr;
      lat_we    <= gnt_we;
      lat_wdata <= gnt_wdata;
      lat_wstrb <= gnt_wstrb;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven single requests, a response scoreboard,
// and hand-written sequences for arbitration order and reset during a read-merge-write.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;     // 0 = round-robin instance, 1 = fixed-priority instance
  logic        m0_valid, m0_we, m1_valid, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  logic        m0_ready_a, m1_ready_a, m0_rvalid_a, m1_rvalid_a, mem_we_a;
  logic [31:0] m0_rdata_a, m1_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        m0_ready_b, m1_ready_b, m0_rvalid_b, m1_rvalid_b, mem_we_b;
  logic [31:0] m0_rdata_b, m1_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  dmem_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid & ~sel), .m0_ready(m0_ready_a), .m0_addr(m0_addr), .m0_we(m0_we),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rvalid(m0_rvalid_a), .m0_rdata(m0_rdata_a),
    .m1_valid(m1_valid & ~sel), .m1_ready(m1_ready_a), .m1_addr(m1_addr), .m1_we(m1_we),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rvalid(m1_rvalid_a), .m1_rdata(m1_rdata_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a), .mem_rdata(mem_rdata_a)
  );

  dmem_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid & sel), .m0_ready(m0_ready_b), .m0_addr(m0_addr), .m0_we(m0_we),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rvalid(m0_rvalid_b), .m0_rdata(m0_rdata_b),
    .m1_valid(m1_valid & sel), .m1_ready(m1_ready_b), .m1_addr(m1_addr), .m1_we(m1_we),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rvalid(m1_rvalid_b), .m1_rdata(m1_rdata_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .mem_rdata(mem_rdata_b)
  );

  logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata;
  assign m0_ready  = sel ? m0_ready_b  : m0_ready_a;
  assign m1_ready  = sel ? m1_ready_b  : m1_ready_a;
  assign m0_rvalid = sel ? m0_rvalid_b : m0_rvalid_a;
  assign m1_rvalid = sel ? m1_rvalid_b : m1_rvalid_a;
  assign m0_rdata  = sel ? m0_rdata_b  : m0_rdata_a;
  assign m1_rdata  = sel ? m1_rdata_b  : m1_rdata_a;
  assign mem_we    = sel ? mem_we_b    : mem_we_a;

  function automatic logic [31:0] init_word(input int i);
    return {8'h5A, 8'(i), 8'(~i), 8'(i * 3)};
  endfunction

  // dmem models: read-first, registered read data
  logic [31:0] dm_a [64];
  logic [31:0] dm_b [64];
  logic        seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 64; i++) begin
        dm_a[i] <= init_word(i);
        dm_b[i] <= init_word(i);
      end
      seeded <= 1'b1;
    end else begin
      if (mem_we_a) dm_a[mem_addr_a[7:2]] <= mem_wdata_a;
      if (mem_we_b) dm_b[mem_addr_b[7:2]] <= mem_wdata_b;
    end
    mem_rdata_a <= dm_a[mem_addr_a[7:2]];
    mem_rdata_b <= dm_b[mem_addr_b[7:2]];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: reference memory plus expected responses in accept order
  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } resp_t;

  resp_t       sb[$];
  int          grant_log[$];
  logic [31:0] ref_mem [int];
  int          we_cnt = 0;
  bit          sb_en  = 1'b1;

  function automatic logic [31:0] ref_rd(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  task automatic sb_accept(input logic id, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    int          idx;
    logic [31:0] w;
    resp_t       r;
    idx = int'(addr[7:2]);
    w   = ref_rd(idx);
    r.id = id;
    if (we) begin
      for (int b = 0; b < 4; b++) if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[idx] = w;
      r.data = '0;
    end else begin
      r.data = w;
    end
    sb.push_back(r);
    grant_log.push_back(int'(id));
  endtask

  always @(negedge clk) begin
    resp_t r;
    if (mem_we) we_cnt++;
    if (rst_n && sb_en) begin
      if (m0_valid && m0_ready) sb_accept(1'b0, m0_we, m0_addr, m0_wdata, m0_wstrb);
      if (m1_valid && m1_ready) sb_accept(1'b1, m1_we, m1_addr, m1_wdata, m1_wstrb);
    end
    if (sb_en && (m0_rvalid || m1_rvalid)) begin
      check("rvalid_onehot", {31'b0, m0_rvalid & m1_rvalid}, 32'd0);
      if (sb.size() == 0) begin
        check("sb_unexpected_rvalid", {31'b0, m0_rvalid | m1_rvalid}, 32'd0);
      end else begin
        r = sb.pop_front();
        check("sb_id", {31'b0, m1_rvalid}, {31'b0, r.id});
        check("sb_rdata", m1_rvalid ? m1_rdata : m0_rdata, r.data);
      end
    end
  end

  task automatic set_port(input bit p, input logic v, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    if (p) begin
      m1_valid = v; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
    end else begin
      m0_valid = v; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  task automatic run_vec(input vec_t v, input int n);
    int          we0, lat;
    bit          got;
    logic [31:0] rd;
    @(posedge clk); #1;
    we0 = we_cnt;
    set_port(v.port, 1'b1, v.we, v.addr, v.wdata, v.wstrb);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = v.port ? m1_ready : m0_ready;
    end
    check($sformatf("vec%0d_accept", n), {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    set_port(v.port, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    got = 1'b0; lat = -1; rd = 'x;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (v.port ? m1_rvalid : m0_rvalid) begin
        got = 1'b1; lat = k; rd = v.port ? m1_rdata : m0_rdata;
        break;
      end
    end
    check($sformatf("vec%0d_latency", n), lat, v.exp_lat);
    check($sformatf("vec%0d_rdata", n), rd, v.exp_rdata);
    check($sformatf("vec%0d_we_pulses", n), we_cnt - we0, v.exp_we);
  endtask

  // Holds valid continuously across n back-to-back loads from one port
  task automatic drive_port(input bit p, input int n, input logic [31:0] base);
    bit got;
    for (int k = 0; k < n; k++) begin
      set_port(p, 1'b1, 1'b0, base + 32'(4 * k), 32'h0, 4'h0);
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk);
        got = p ? m1_ready : m0_ready;
      end
      check($sformatf("port%0d_req%0d_accept", p, k), {31'b0, got}, 32'd1);
      @(posedge clk); #1;
    end
    set_port(p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1, 1};
    vecs[1] = '{0, 0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1, 0};
    vecs[2] = '{1, 1, 32'h20, 32'h11223344, 4'hF, 32'h0,        1, 1};
    vecs[3] = '{1, 1, 32'h20, 32'h0000AA00, 4'h2, 32'h0,        2, 1};
    vecs[4] = '{0, 0, 32'h20, 32'h0,        4'h0, 32'h1122AA44, 1, 0};
    vecs[5] = '{0, 1, 32'h30, 32'h00000055, 4'hF, 32'h0,        1, 1};
    vecs[6] = '{1, 1, 32'h30, 32'hFFFFFFFF, 4'h0, 32'h0,        1, 0};
    vecs[7] = '{1, 0, 32'h30, 32'h0,        4'h0, 32'h00000055, 1, 0};
    vecs[8] = '{0, 1, 32'h13, 32'hCAFEF00D, 4'h9, 32'h0,        2, 1};
    vecs[9] = '{1, 0, 32'h12, 32'h0,        4'h0, 32'hCAADBE0D, 1, 0};

    sel = 1'b0;
    rst_n = 1'b0;
    set_port(1'b0, 1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF);
    set_port(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);

    // Reset state: no handshake or dmem write while rst_n is low, responses cleared
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m0_ready", {31'b0, m0_ready}, 32'd0);
    check("rst_m1_ready", {31'b0, m1_ready}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    check("rst_m1_rdata", m1_rdata, 32'd0);
    @(posedge clk); #1;
    set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b1;

    // Single requests: full/partial/empty stores and loads on both ports
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset during the MERGE cycle of a partial store
    begin
      int  we0;
      bit  rv_seen, got;
      @(posedge clk); #1;
      sb_en = 1'b0;
      we0 = we_cnt;
      set_port(1'b0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'h3);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        got = m0_ready;
      end
      check("merge_rst_accept", {31'b0, got}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      rv_seen = 1'b0;
      repeat (2) begin
        @(negedge clk);
        rv_seen |= m0_rvalid | m1_rvalid;
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        rv_seen |= m0_rvalid | m1_rvalid;
      end
      check("merge_rst_no_we", we_cnt - we0, 32'd0);
      check("merge_rst_no_rvalid", {31'b0, rv_seen}, 32'd0);
      sb_en = 1'b1;
      @(posedge clk); #1;
      set_port(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      @(negedge clk);
      check("post_rst_ready", {31'b0, m0_ready}, 32'd1);
      @(posedge clk); #1;
      set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) @(posedge clk);
      #1;
    end

    // Round-robin: both ports continuously valid after reset
    do_reset();
    grant_log.delete();
    fork
      drive_port(1'b0, 3, 32'h44);
      drive_port(1'b1, 3, 32'h60);
    join
    repeat (4) @(posedge clk);
    #1;
    check("rr_grant_count", grant_log.size(), 32'd6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_grant%0d", k),
            (k < grant_log.size()) ? grant_log[k] : -1, k % 2);
    end

    // Fixed priority: m1 waits until m0 drops valid
    sel = 1'b1;
    do_reset();
    grant_log.delete();
    fork
      drive_port(1'b0, 3, 32'h80);
      drive_port(1'b1, 1, 32'hA0);
    join
    repeat (4) @(posedge clk);
    #1;
    check("fp_grant_count", grant_log.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fp_grant%0d", k),
            (k < grant_log.size()) ? grant_log[k] : -1, (k == 3) ? 1 : 0);
    end

    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
